mux_decoded_pipe: RTL and testbench



---
 rtl/mux_decoded_pipe.sv | 152 +++++++++++++++
 tb/tb_mux_decoded_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_decoded_pipe.sv
// mux_decoded_pipe
// Pipelined, flow-controlled one-hot way selector. Each accepted request is
// reduced to one way, a miss flag and a multi-hot flag, and stored in a
// small circular output buffer with valid/ready handshaking on both sides.
//
// Ports
//   clk_in           clock, all state updates on the rising edge
//   reset_in         synchronous, active-high reset
//   way_flatted_in   NUM_WAY ways, way i at bits [i*W +: W]
//   sel_in           decoded select, bit i selects way i
//   valid_in         request valid
//   ready_out        buffer has room (function of occupancy only)
//   way_flatted_out  selected way at buffer head (0 when empty)
//   valid_out        head entry valid
//   ready_in         downstream accepts head
//   miss_out         head entry had an all-zero select (0 when empty)
//   multi_hot_out    head entry had several select bits set (0 when empty)
//
// Build option
//   MUX_DECODED_PIPE_PRIORITY_EN  when defined, a multi-hot select resolves
//                                 to the lowest-index selected way; when
//                                 undefined, all selected ways are ORed.

module mux_decoded_pipe #(
  parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int unsigned NUM_WAY                  = 8,
  parameter int unsigned BUFFER_DEPTH             = 2
) (
  input  logic                                        clk_in,
  input  logic                                        reset_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_in,
  input  logic [NUM_WAY-1:0]                          sel_in,
  input  logic                                        valid_in,
  output logic                                        ready_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         way_flatted_out,
  output logic                                        valid_out,
  input  logic                                        ready_in,
  output logic                                        miss_out,
  output logic                                        multi_hot_out
);

  localparam int unsigned W     = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUFFER_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUFFER_DEPTH - 1);

  // One buffered result: selected way plus its select-quality flags.
  typedef struct packed {
    logic [W-1:0] data;
    logic         miss;
    logic         multi_hot;
  } entry_t;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == LAST_PTR) n = '0;
    else               n = p + PTR_W'(1);
    return n;
  endfunction

  // ---------------------------------------------------------------------
  // Select datapath, evaluated before the push
  // ---------------------------------------------------------------------
  logic [W-1:0] sel_result_c;
  logic         sel_miss_c;
  logic         sel_multi_c;

`ifdef MUX_DECODED_PIPE_PRIORITY_EN
  // Lowest-index set bit wins; later matches are ignored once one is found.
  logic sel_found_c;

  always_comb begin
    sel_result_c = '0;
    sel_found_c  = 1'b0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (sel_in[i] && !sel_found_c) begin
        sel_result_c = way_flatted_in[i*W +: W];
        sel_found_c  = 1'b1;
      end
    end
  end
`else
  // AND-OR mux: every selected way contributes to the result.
  always_comb begin
    sel_result_c = '0;
    for (int i = 0; i < NUM_WAY; i++) begin
      sel_result_c = sel_result_c | (way_flatted_in[i*W +: W] & {W{sel_in[i]}});
    end
  end
`endif

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    sel_miss_c  = ~|sel_in;
    sel_multi_c = |(sel_in & (sel_in - NUM_WAY'(1)));
  end

  // ---------------------------------------------------------------------
  // Output buffer control
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic             push_c;
  logic             pop_c;

  // ready_out depends on occupancy only, so a full buffer refuses a push
  // even when the head is popped in the same cycle.
  assign ready_out = (count_q < DEPTH_CNT);
  assign valid_out = (count_q != '0);
  assign push_c    = valid_in && ready_out;
  assign pop_c     = valid_out && ready_in;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Storage: contents are qualified by count_q, so no reset is needed
  // ---------------------------------------------------------------------
  entry_t mem_q [BUFFER_DEPTH];
  entry_t head_c;

  always_ff @(posedge clk_in) begin
    if (push_c && !reset_in) begin
      mem_q[wr_ptr_q] <= '{data: sel_result_c, miss: sel_miss_c, multi_hot: sel_multi_c};
    end
  end

  assign head_c = mem_q[rd_ptr_q];

  // Head fields are forced to zero whenever no entry is valid.
  assign way_flatted_out = head_c.data & {W{valid_out}};
  assign miss_out        = head_c.miss & valid_out;
  assign multi_hot_out   = head_c.multi_hot & valid_out;

endmodule

// File: tb/tb_mux_decoded_pipe.sv
// Scoreboard bench for mux_decoded_pipe: expected entries are queued when a
// request is accepted and compared when the head is popped.
module tb_mux_decoded_pipe;

  localparam int unsigned W     = 4;
  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 2;

  logic             clk_in = 1'b0;
  logic             reset_in;
  logic [W*N-1:0]   way_flatted_in;
  logic [N-1:0]     sel_in;
  logic             valid_in;
  logic             ready_out;
  logic [W-1:0]     way_flatted_out;
  logic             valid_out;
  logic             ready_in;
  logic             miss_out;
  logic             multi_hot_out;

  mux_decoded_pipe #(
    .SINGLE_WAY_WIDTH_IN_BITS(W),
    .NUM_WAY(N),
    .BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .way_flatted_in(way_flatted_in),
    .sel_in(sel_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .way_flatted_out(way_flatted_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .miss_out(miss_out),
    .multi_hot_out(multi_hot_out)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [W+1:0] sb_q [$];
  logic [W+1:0] pending_exp;
  logic         acc;

  localparam logic [W*N-1:0] WAYS = {4'ha, 4'hb, 4'hc, 4'hd, 4'h1, 4'h2, 4'h3, 4'h4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: {data, miss, multi_hot}.
  function automatic logic [W+1:0] model(input logic [W*N-1:0] ways, input logic [N-1:0] sel);
    logic [W-1:0] d;
    int ones;
    d = '0;
    ones = 0;
`ifdef MUX_DECODED_PIPE_PRIORITY_EN
    for (int i = N - 1; i >= 0; i--) if (sel[i]) d = ways[i*W +: W];
`else
    for (int i = 0; i < N; i++) if (sel[i]) d = d | ways[i*W +: W];
`endif
    for (int i = 0; i < N; i++) ones += int'(sel[i]);
    return {d, ones == 0, ones > 1};
  endfunction

  // One clock: inputs already driven after a negedge; check, then advance.
  task automatic cycle(output logic accepted);
    #1;
    check("valid_out", 32'(valid_out), 32'(sb_q.size() != 0));
    check("ready_out", 32'(ready_out), 32'(sb_q.size() < DEPTH));
    if (!valid_out) begin
      check("masked", 32'({way_flatted_out, miss_out, multi_hot_out}), 32'd0);
    end else if (ready_in && !reset_in && sb_q.size() != 0) begin
      check("head", 32'({way_flatted_out, miss_out, multi_hot_out}), 32'(sb_q.pop_front()));
    end
    accepted = valid_in && ready_out && !reset_in;
    if (accepted) sb_q.push_back(pending_exp);
    if (reset_in) sb_q.delete();
    @(negedge clk_in);
  endtask

  task automatic send(input logic [N-1:0] sel, input logic [W+1:0] exp);
    logic a;
    sel_in      = sel;
    pending_exp = exp;
    valid_in    = 1'b1;
    a = 1'b0;
    for (int k = 0; k < 20 && !a; k++) cycle(a);
    if (!a) check("accept_timeout", 32'd0, 32'd1);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    logic a;
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) cycle(a);
    check("drained", 32'(sb_q.size()), 32'd0);
    cycle(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in       = 1'b1;
    valid_in       = 1'b0;
    ready_in       = 1'b1;
    sel_in         = '0;
    way_flatted_in = WAYS;
    pending_exp    = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_outs", 32'({way_flatted_out, miss_out, multi_hot_out}), 32'd0);
    @(negedge clk_in);

    // 1: single one-hot request
    send(8'b0010_0000, {4'hc, 1'b0, 1'b0});
    drain();
    // 2: zero-hot
    send(8'b0000_0000, {4'h0, 1'b1, 1'b0});
    drain();
    // 3: multi-hot
`ifdef MUX_DECODED_PIPE_PRIORITY_EN
    send(8'b0000_0011, {4'h4, 1'b0, 1'b1});
`else
    send(8'b0000_0011, {4'h7, 1'b0, 1'b1});
`endif
    drain();

    // 4: backpressure fills the buffer, third request waits
    ready_in = 1'b0;
    send(8'h01, {4'h4, 1'b0, 1'b0});
    send(8'h02, {4'h3, 1'b0, 1'b0});
    sel_in = 8'h04; pending_exp = {4'h2, 1'b0, 1'b0}; valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(acc);
      check("full_stall", 32'(acc), 32'd0);
    end
    ready_in = 1'b1;
    send(8'h04, {4'h2, 1'b0, 1'b0});
    drain();

    // 5: steady streaming at count=1
    ready_in = 1'b0;
    send(8'h80, {4'ha, 1'b0, 1'b0});
    ready_in = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < N; i++) begin
      sel_in      = N'(1) << i;
      pending_exp = {WAYS[i*W +: W], 1'b0, 1'b0};
      cycle(acc);
      check("stream_accept", 32'(acc), 32'd1);
    end
    drain();

    // 6: reset while full, with a request presented during reset
    ready_in = 1'b0;
    send(8'h01, {4'h4, 1'b0, 1'b0});
    send(8'h02, {4'h3, 1'b0, 1'b0});
    reset_in = 1'b1; valid_in = 1'b1; sel_in = 8'h08;
    cycle(acc);
    reset_in = 1'b0; valid_in = 1'b0;
    #1;
    check("rst6_valid", 32'(valid_out), 32'd0);
    check("rst6_ready", 32'(ready_out), 32'd1);
    check("rst6_outs", 32'({way_flatted_out, miss_out, multi_hot_out}), 32'd0);
    @(negedge clk_in);
    ready_in = 1'b1;
    send(8'h10, {4'hd, 1'b0, 1'b0});
    drain();

    // Random traffic with biased selects
    for (int k = 0; k < 300; k++) begin
      way_flatted_in = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       sel_in = '0;
        1:       sel_in = N'($urandom);
        default: sel_in = N'(1) << $urandom_range(0, N - 1);
      endcase
      pending_exp = model(way_flatted_in, sel_in);
      valid_in    = 1'($urandom_range(0, 1));
      ready_in    = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
